// File: rtl/conv_engine_pkg.sv
// conv_engine_pkg: shared types and helpers for conv_engine_param.
// Holds the FSM state encoding, the derived-size helpers (output side,
// tap count, load length, index widths) and the requantisation function.
package conv_engine_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    COMPUTE,
    OUTPUT,
    DONE
  } state_t;

  // Output map side: N-K+1
  function automatic int out_n(input int n, input int k);
    return n - k + 1;
  endfunction

  // Kernel taps per output pixel: K*K
  function automatic int ntaps(input int k);
    return k * k;
  endfunction

  // Words fetched per run: all weights followed by all features
  function automatic int nload(input int n, input int k);
    return k * k + n * n;
  endfunction

  // Index width for a counter spanning 0..n-1, never narrower than 1 bit
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Arithmetic shift (floor), optional ReLU, then saturate to a signed
  // out_w-bit range. Works on 64 bits so any legal ACC_W fits.
  function automatic logic signed [63:0] requant(input logic signed [63:0] acc,
                                                 input int                 shift,
                                                 input logic               relu,
                                                 input int                 out_w);
    logic signed [63:0] y;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    y  = acc >>> shift;
    if (relu && (y < 64'sd0)) y = 64'sd0;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_w - 1));
    if (y > hi)      y = hi;
    else if (y < lo) y = lo;
    return y;
  endfunction

endpackage

// File: rtl/conv_engine_param_mac.sv
// conv_mac_unit: one signed multiply-accumulate per cycle while i_vld.
// Ports: i_w/i_f operands, i_first clears the running sum, i_last requantises
// the final sum into o_dat, which then holds until the next last tap.
module conv_mac_unit
  import conv_engine_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20,
  parameter int OUT_W  = 8,
  parameter int SHIFT  = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_vld,
  input  logic                     i_first,
  input  logic                     i_last,
  input  logic                     i_relu,
  input  logic signed [DATA_W-1:0] i_w,
  input  logic signed [DATA_W-1:0] i_f,
  output logic        [OUT_W-1:0]  o_dat
);

  logic signed [2*DATA_W-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_prod_ext;
  logic signed [ACC_W-1:0]    w_sum;
  logic signed [63:0]         w_q;
  logic signed [ACC_W-1:0]    r_acc;
  logic        [OUT_W-1:0]    r_out;

  assign w_prod     = i_w * i_f;
  assign w_prod_ext = ACC_W'(w_prod);
  // First tap starts a fresh sum rather than adding to the previous pixel
  assign w_sum      = (i_first ? '0 : r_acc) + w_prod_ext;
  assign w_q        = requant(64'(w_sum), SHIFT, i_relu, OUT_W);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_out <= '0;
    end else if (i_vld) begin
      r_acc <= w_sum;
      if (i_last) r_out <= w_q[OUT_W-1:0];
    end
  end

  assign o_dat = r_out;

endmodule

// File: rtl/conv_engine_param.sv
// conv_engine_param: loads a KxK kernel and NxN feature map from sync memory,
// then streams (N-K+1)^2 requantised conv outputs over valid/ready.
// Ports: en/is_done_o to the mode FSM, addr_o/data_i to memory, out_* stream.
module conv_engine_param
  import conv_engine_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 6,
  parameter int IFM_N     = 3,
  parameter int KER_K     = 2,
  parameter int ACC_W     = 20,
  parameter int OUT_W     = 8,
  parameter int SHIFT     = 0,
  parameter int BASE_ADDR = 0
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   en,
  input  logic                                   relu_i,
  input  logic [DATA_W-1:0]                      data_i,
  output logic [ADDR_W-1:0]                      addr_o,
  output logic [OUT_W-1:0]                       out_data_o,
  output logic [idx_w(IFM_N-KER_K+1)-1:0]        out_row_o,
  output logic [idx_w(IFM_N-KER_K+1)-1:0]        out_col_o,
  output logic                                   out_last_o,
  output logic                                   out_valid_o,
  input  logic                                   out_ready_i,
  output logic                                   is_done_o
);

  localparam int OUT_N = out_n(IFM_N, KER_K);
  localparam int NTAPS = ntaps(KER_K);
  localparam int NLOAD = nload(IFM_N, KER_K);
  localparam int RC_W  = idx_w(OUT_N);
  localparam int K_W   = idx_w(KER_K);
  localparam int CNT_W = idx_w(NLOAD + 1);
  localparam int W_IW  = idx_w(NTAPS);
  localparam int F_IW  = idx_w(IFM_N * IFM_N);

  state_t              r_state, w_next;
  logic                r_relu;
  logic [CNT_W-1:0]    r_cnt;
  logic [K_W-1:0]      r_ki, r_kj;
  logic [RC_W-1:0]     r_row, r_col;
  logic signed [DATA_W-1:0] r_w [NTAPS];
  logic signed [DATA_W-1:0] r_f [IFM_N*IFM_N];

  logic                w_first, w_last_tap, w_last_col, w_last_px;
  logic [W_IW-1:0]     w_widx;
  logic [F_IW-1:0]     w_fidx;
  int                  w_lidx;

  assign w_first    = (r_ki == '0) && (r_kj == '0);
  assign w_last_tap = (r_ki == K_W'(KER_K - 1)) && (r_kj == K_W'(KER_K - 1));
  assign w_last_col = (r_col == RC_W'(OUT_N - 1));
  assign w_last_px  = w_last_col && (r_row == RC_W'(OUT_N - 1));
  assign w_widx     = W_IW'(int'(r_ki) * KER_K + int'(r_kj));
  assign w_fidx     = F_IW'((int'(r_row) + int'(r_ki)) * IFM_N + int'(r_col) + int'(r_kj));
  // Load data lags its address by one cycle, so r_cnt=j captures word j-1
  assign w_lidx     = int'(r_cnt) - 1;

  always_comb begin
    w_next      = r_state;
    addr_o      = '0;
    out_valid_o = 1'b0;
    out_last_o  = 1'b0;
    is_done_o   = 1'b0;
    case (r_state)
      IDLE:    if (en) w_next = LOAD;
      LOAD: begin
        if (r_cnt < CNT_W'(NLOAD)) addr_o = ADDR_W'(BASE_ADDR) + ADDR_W'(r_cnt);
        if (r_cnt == CNT_W'(NLOAD)) w_next = COMPUTE;
      end
      COMPUTE: if (w_last_tap) w_next = OUTPUT;
      OUTPUT: begin
        out_valid_o = 1'b1;
        out_last_o  = w_last_px;
        if (out_ready_i) w_next = w_last_px ? DONE : COMPUTE;
      end
      DONE: begin
        is_done_o = 1'b1;
        if (!en) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_relu  <= 1'b0;
      r_cnt   <= '0;
      r_ki    <= '0;
      r_kj    <= '0;
      r_row   <= '0;
      r_col   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          r_ki  <= '0;
          r_kj  <= '0;
          r_row <= '0;
          r_col <= '0;
          if (en) r_relu <= relu_i;
        end
        LOAD: r_cnt <= r_cnt + 1'b1;
        COMPUTE: begin
          if (r_kj == K_W'(KER_K - 1)) begin
            r_kj <= '0;
            r_ki <= w_last_tap ? '0 : r_ki + 1'b1;
          end else begin
            r_kj <= r_kj + 1'b1;
          end
        end
        OUTPUT: begin
          if (out_ready_i) begin
            if (w_last_col) begin
              r_col <= '0;
              r_row <= r_row + 1'b1;
            end else begin
              r_col <= r_col + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Operand arrays carry no reset: every entry is rewritten before use
  always_ff @(posedge clk) begin
    if (!rst && (r_state == LOAD) && (r_cnt != '0)) begin
      if (w_lidx < NTAPS) r_w[W_IW'(w_lidx)]         <= data_i;
      else                r_f[F_IW'(w_lidx - NTAPS)] <= data_i;
    end
  end

  conv_mac_unit #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .OUT_W  (OUT_W),
    .SHIFT  (SHIFT)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .i_vld   (r_state == COMPUTE),
    .i_first (w_first),
    .i_last  (w_last_tap),
    .i_relu  (r_relu),
    .i_w     (r_w[w_widx]),
    .i_f     (r_f[w_fidx]),
    .o_dat   (out_data_o)
  );

  assign out_row_o = r_row;
  assign out_col_o = r_col;

endmodule

// File: tb/tb_conv_engine_param.sv
// Directed bench for conv_engine_param: default config, SHIFT=2 and N=4/K=3
// instances share one memory image; each step checks hand-computed results.
module tb_conv_engine_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en_a, en_b, relu, rdy;
  logic [7:0] mem [64];
  logic [7:0] d_a, d_s, d_b;
  logic [5:0] addr_a, addr_s, addr_b;
  logic signed [7:0] dat_a, dat_s, dat_b;
  logic row_a, col_a, last_a, vld_a, done_a;
  logic row_s, col_s, last_s, vld_s, done_s;
  logic row_b, col_b, last_b, vld_b, done_b;

  int n_chk = 0;
  int n_err = 0;
  int qa_d[$], qa_p[$], qs_d[$], qs_p[$], qb_d[$], qb_p[$];
  int nz_b = 0;
  int max_b = 0;

  conv_engine_param u_dut (
    .clk(clk), .rst(rst), .en(en_a), .relu_i(relu), .data_i(d_a), .addr_o(addr_a),
    .out_data_o(dat_a), .out_row_o(row_a), .out_col_o(col_a), .out_last_o(last_a),
    .out_valid_o(vld_a), .out_ready_i(rdy), .is_done_o(done_a));

  conv_engine_param #(.SHIFT(2)) u_sh (
    .clk(clk), .rst(rst), .en(en_a), .relu_i(relu), .data_i(d_s), .addr_o(addr_s),
    .out_data_o(dat_s), .out_row_o(row_s), .out_col_o(col_s), .out_last_o(last_s),
    .out_valid_o(vld_s), .out_ready_i(rdy), .is_done_o(done_s));

  conv_engine_param #(.IFM_N(4), .KER_K(3)) u_big (
    .clk(clk), .rst(rst), .en(en_b), .relu_i(relu), .data_i(d_b), .addr_o(addr_b),
    .out_data_o(dat_b), .out_row_o(row_b), .out_col_o(col_b), .out_last_o(last_b),
    .out_valid_o(vld_b), .out_ready_i(rdy), .is_done_o(done_b));

  // Synchronous memory: read data one cycle after the address
  always @(posedge clk) begin
    d_a <= mem[addr_a];
    d_s <= mem[addr_s];
    d_b <= mem[addr_b];
  end

  // Handshake monitor; position packed as row*4 + col*2 + last
  always @(negedge clk) begin
    if (!rst && rdy) begin
      if (vld_a) begin qa_d.push_back(int'(dat_a)); qa_p.push_back(int'(row_a)*4 + int'(col_a)*2 + int'(last_a)); end
      if (vld_s) begin qs_d.push_back(int'(dat_s)); qs_p.push_back(int'(row_s)*4 + int'(col_s)*2 + int'(last_s)); end
      if (vld_b) begin qb_d.push_back(int'(dat_b)); qb_p.push_back(int'(row_b)*4 + int'(col_b)*2 + int'(last_b)); end
    end
    if (en_b && addr_b != 6'd0) begin
      nz_b++;
      if (int'(addr_b) > max_b) max_b = int'(addr_b);
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input string tag, input bit sel_b);
    int n = 0;
    while (!(sel_b ? done_b : done_a) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(tag, int'(sel_b ? done_b : done_a), 1);
  endtask

  task automatic chk_stream(input string tag, input int qd[$], input int qp[$], input int base,
                            input int e0, input int e1, input int e2, input int e3);
    int e[4];
    int p[4];
    e = '{e0, e1, e2, e3};
    p = '{0, 2, 4, 7};
    chk({tag, "_cnt"}, qd.size() - base, 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_d%0d", tag, i), (base + i < qd.size()) ? qd[base + i] : -999, e[i]);
      chk($sformatf("%s_p%0d", tag, i), (base + i < qp.size()) ? qp[base + i] : -999, p[i]);
    end
  endtask

  task automatic load_mem(input int w0, input int w1, input int w2, input int w3, input int fv);
    mem[0] = 8'(w0); mem[1] = 8'(w1); mem[2] = 8'(w2); mem[3] = 8'(w3);
    for (int i = 0; i < 9; i++) mem[4 + i] = (fv == 0) ? 8'(i + 1) : 8'(fv);
  endtask

  task automatic run_a(input string tag);
    cyc(); en_a = 1'b1;
    wait_done(tag, 1'b0);
    cyc(); en_a = 1'b0;
    cyc();
  endtask

  task automatic chk_idle_reset(input string tag);
    chk({tag, "_addr"}, int'(addr_a), 0);
    chk({tag, "_vld"},  int'(vld_a), 0);
    chk({tag, "_dat"},  int'(dat_a), 0);
    chk({tag, "_row"},  int'(row_a), 0);
    chk({tag, "_col"},  int'(col_a), 0);
    chk({tag, "_last"}, int'(last_a), 0);
    chk({tag, "_done"}, int'(done_a), 0);
  endtask

  initial begin
    int ba, bs, bb, n;
    for (int i = 0; i < 64; i++) mem[i] = 8'd0;
    rst = 1'b1; en_a = 1'b0; en_b = 1'b0; relu = 1'b0; rdy = 1'b1;
    repeat (3) cyc();
    chk_idle_reset("reset");
    rst = 1'b0;
    cyc();

    // Identity-diagonal kernel, features 1..9; also SHIFT=2 instance
    load_mem(1, 0, 0, 1, 0);
    ba = qa_d.size(); bs = qs_d.size();
    cyc(); en_a = 1'b1;
    cyc();
    for (int i = 0; i < 13; i++) begin
      chk($sformatf("addr%0d", i), int'(addr_a), i);
      cyc();
    end
    chk("addr_end", int'(addr_a), 0);
    wait_done("done_basic", 1'b0);
    chk_stream("basic", qa_d, qa_p, ba, 6, 8, 12, 14);
    chk_stream("shift2", qs_d, qs_p, bs, 1, 2, 3, 3);
    repeat (10) cyc();
    chk("done_hold", int'(done_a), 1);
    chk("one_run", qa_d.size() - ba, 4);
    en_a = 1'b0;
    cyc();
    chk("done_drop", int'(done_a), 0);
    cyc();

    // Backpressure on the second pixel
    ba = qa_d.size();
    cyc(); en_a = 1'b1;
    n = 0;
    while (!vld_a && n < 100) begin @(negedge clk); n++; end
    chk("stall_first_vld", int'(vld_a), 1);
    cyc(); rdy = 1'b0;
    n = 0;
    @(negedge clk);
    while (!vld_a && n < 100) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("stall_vld%0d", i), int'(vld_a), 1);
      chk($sformatf("stall_dat%0d", i), int'(dat_a), 8);
      chk($sformatf("stall_pos%0d", i), int'(row_a)*2 + int'(col_a), 1);
      @(negedge clk);
    end
    cyc(); rdy = 1'b1;
    wait_done("done_stall", 1'b0);
    chk_stream("stall", qa_d, qa_p, ba, 6, 8, 12, 14);
    cyc(); en_a = 1'b0;
    cyc();

    // Saturation both ways
    load_mem(127, 127, 127, 127, 127);
    ba = qa_d.size();
    run_a("done_satp");
    chk_stream("satp", qa_d, qa_p, ba, 127, 127, 127, 127);
    load_mem(-128, -128, -128, -128, 127);
    ba = qa_d.size();
    run_a("done_satn");
    chk_stream("satn", qa_d, qa_p, ba, -128, -128, -128, -128);

    // Negative kernel with and without ReLU
    load_mem(-1, 0, 0, 0, 0);
    ba = qa_d.size();
    run_a("done_neg");
    chk_stream("neg", qa_d, qa_p, ba, -1, -2, -4, -5);
    relu = 1'b1;
    ba = qa_d.size();
    run_a("done_relu");
    chk_stream("relu", qa_d, qa_p, ba, 0, 0, 0, 0);
    relu = 1'b0;

    // N=4, K=3: weights all 1, features 1..16 -> 9 * window centre
    for (int i = 0; i < 9; i++)  mem[i] = 8'd1;
    for (int i = 0; i < 16; i++) mem[9 + i] = 8'(i + 1);
    bb = qb_d.size();
    cyc(); en_b = 1'b1;
    wait_done("done_big", 1'b1);
    chk_stream("big", qb_d, qb_p, bb, 54, 63, 90, 99);
    chk("big_addr_nz", nz_b, 24);
    chk("big_addr_max", max_b, 24);
    cyc(); en_b = 1'b0;
    cyc();

    // Reset during the third pixel's compute, then a clean rerun
    load_mem(1, 0, 0, 1, 0);
    ba = qa_d.size();
    cyc(); en_a = 1'b1;
    n = 0;
    while (qa_d.size() < ba + 2 && n < 200) begin @(negedge clk); n++; end
    chk("mid_two_px", qa_d.size() - ba, 2);
    cyc();
    rst = 1'b1; en_a = 1'b0;
    cyc();
    chk_idle_reset("midrst");
    rst = 1'b0;
    repeat (3) cyc();
    chk("midrst_no_partial", qa_d.size() - ba, 2);
    ba = qa_d.size();
    run_a("done_rerun");
    chk_stream("rerun", qa_d, qa_p, ba, 6, 8, 12, 14);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/conv_engine_param.md
Name: conv_engine_param

Overview:
- Parametrised successor to the fixed 2x2-output convolution mode block.
- Fetches a KxK signed kernel and an NxN signed input feature map from synchronous memory into internal register arrays.
- Computes all (N-K+1)^2 outputs with a sequential MAC, requantises each result (shift, optional ReLU, saturate) and streams it out with a valid/ready handshake.
- Sits between the mode FSM (en / is_done_o) and the output consumer.

Parameters:
- DATA_W, 8: signed weight/feature width.
- ADDR_W, 6: memory address width.
- IFM_N, 3: input feature map side N.
- KER_K, 2: kernel side K; requires K <= N.
- ACC_W, 20: accumulator width; requires ACC_W >= 2*DATA_W + clog2(K*K).
- OUT_W, 8: signed output width.
- SHIFT, 0: arithmetic right shift applied before saturation.
- BASE_ADDR, 0: address of weight 0. Features follow contiguously at BASE_ADDR+K*K, row-major.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- en  input  1  start request from FSM; sampled in IDLE only
- relu_i  input  1  ReLU mode; sampled at start and held for the run
- data_i  input  DATA_W  memory read data, valid one cycle after addr_o
- addr_o  output  ADDR_W  memory read address
- out_data_o  output  OUT_W  requantised output pixel
- out_row_o  output  clog2(N-K+1) (min 1)  output row index
- out_col_o  output  clog2(N-K+1) (min 1)  output column index
- out_last_o  output  1  high with the final pixel
- out_valid_o  output  1  output pixel valid
- out_ready_i  input  1  consumer ready
- is_done_o  output  1  run complete

Behaviour:
- Single clock. Reset is synchronous and active-high (rst on clk). Reset forces: state IDLE, addr_o=0, out_valid_o=0, out_data_o=0, out_row_o=0, out_col_o=0, out_last_o=0, is_done_o=0, all counters and the accumulator cleared.
- Reset mid-operation aborts immediately with the same values; no partial output is emitted.
- State machine: IDLE -> LOAD -> COMPUTE -> OUTPUT -> (COMPUTE | DONE) -> IDLE.
- IDLE: addr_o=0. en=1 -> LOAD next cycle; relu_i is latched at this transition.
- LOAD:
  - addr_o = BASE_ADDR + i for i = 0..NLOAD-1, one address per cycle, where NLOAD = K*K + N*N.
  - data_i for address i is captured on the following cycle: first K*K values into the weight array, the remainder into the feature array.
  - LOAD lasts NLOAD+1 cycles, then -> COMPUTE. addr_o returns to 0 after the last address.
  - Address arithmetic wraps modulo 2^ADDR_W.
- COMPUTE:
  - Tap counter t = 0..K*K-1, with ki = t/K and kj = t%K.
  - acc = (t==0 ? 0 : acc) + w[t] * f[(r+ki)*N + (c+kj)], using full signed products sign-extended to ACC_W.
  - On t = K*K-1 the final sum is requantised into out_data_o, then -> OUTPUT. One output takes K*K cycles.
- Requantisation, in order:
  - y = acc >>> SHIFT (floor).
  - If relu is latched and y < 0, y = 0.
  - Saturate y to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- OUTPUT:
  - out_valid_o=1; out_data_o, out_row_o, out_col_o and out_last_o are held stable until out_valid_o && out_ready_i.
  - On handshake, out_valid_o drops next cycle and position advances column-first (c++, wrap to 0 with r++).
  - Handshake on the last pixel (r=c=N-K) -> DONE; otherwise -> COMPUTE.
- DONE: is_done_o=1 and held while en=1. When en=0: is_done_o=0 next cycle, -> IDLE. en held high therefore produces exactly one run.
- en changes outside IDLE/DONE are ignored.

Decomposition:
- Package conv_engine_pkg holds:
  - state enum (IDLE, LOAD, COMPUTE, OUTPUT, DONE);
  - derived localparam functions OUT_N = N-K+1, NTAPS = K*K, NLOAD = K*K+N*N;
  - requantisation function (shift, ReLU, saturate).
- One sub-module, conv_mac_unit: signed multiply, accumulate with clear-on-first-tap, and requantise on last tap.
- The parent owns the FSM, counters, address generation and register arrays.

Test Plan:
- Defaults. Memory[0..3] = {1,0,0,1}, memory[4..12] = 1..9, ready=1, en=1 -> addr_o = 0..12 on consecutive cycles; output stream 6,8,12,14 at (0,0),(0,1),(1,0),(1,1); out_last_o only on 14; is_done_o high until en drops.
- Same data, out_ready_i low for 5 cycles when the 2nd pixel is valid -> out_data_o=8 with row 0 / col 1 held stable all 5 cycles; exactly 4 handshakes total.
- Weights all 127, features all 127 -> acc=64516 -> every output saturates to 127. Weights all -128, features all 127 -> every output is -128.
- Weights {-1,0,0,0}, features 1..9: relu_i=0 -> outputs -1,-2,-4,-5; relu_i=1 -> all outputs 0.
- SHIFT=2 with the identity-diagonal data -> outputs 1,2,3,3. N=4, K=3 -> 4 outputs, 25 addresses fetched.
- rst asserted during COMPUTE of the 3rd pixel -> next cycle all outputs are at reset values; a new en run yields the full correct 4-pixel stream.
